// File: rtl/div_seq.sv
// ============================================================================
// Module  : div_seq
// Brief   : Radix-2 restoring divide/remainder unit for DIV, DIVU, REM, REMU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    c_last = CW'(WIDTH-1);

  logic [1:0]       r_state, w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_div, r_result;
  logic             r_qneg, r_rneg, r_is_rem;

  logic             w_signed, w_is_rem, w_accept, w_div0, w_ovf, w_special, w_ge;
  logic [WIDTH-1:0] w_in1_abs, w_in2_abs, w_rem_nx, w_quo_nx, w_final;
  logic [WIDTH:0]   w_rem_sh, w_rem_sub;

  assign w_signed  = ~op[0];
  assign w_is_rem  = op[1];
  assign w_accept  = start && (op[3:2] == 2'b11) && !flush &&
                     ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_div0    = (in2 == '0);
  assign w_ovf     = w_signed && (in1 == c_min) && (in2 == '1);
  assign w_special = w_div0 || w_ovf;
  assign w_in1_abs = (w_signed && in1[WIDTH-1]) ? -in1 : in1;
  assign w_in2_abs = (w_signed && in2[WIDTH-1]) ? -in2 : in2;

  // Shifted partial remainder needs one extra bit so the compare cannot overflow
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_div};
  assign w_ge      = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx  = w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};
  assign w_final   = r_is_rem ? (r_rneg ? -w_rem_nx : w_rem_nx)
                              : (r_qneg ? -w_quo_nx : w_quo_nx);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (flush) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) w_state_nx = w_special ? S_DONE : S_CALC;
          else          w_state_nx = S_IDLE;
        end
        S_CALC:  w_state_nx = (r_cnt == c_last) ? S_DONE : S_CALC;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_CALC) || (r_state == S_DONE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_is_rem <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= w_in1_abs;
      r_div    <= w_in2_abs;
      r_qneg   <= w_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
      r_rneg   <= w_signed && in1[WIDTH-1];
      r_is_rem <= w_is_rem;
      if (w_div0)     r_result <= w_is_rem ? in1 : '1;
      else if (w_ovf) r_result <= w_is_rem ? '0 : in1;
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_last) r_result <= w_final;
    end
  end

  assign result = r_result;

endmodule

`default_nettype wire
